// File: rtl/ula_pkg.sv
// Shared constants and types for the ULA dispatch unit: opcode map, FSM states, flag bit positions.
package ula_pkg;

   localparam int DATA_W  = 8;
   localparam int NREGS   = 4;
   localparam int REG_AW  = 2;
   localparam int FLAG_W  = 4;
   localparam int OP_W    = 4;
   localparam int INSTR_W = 16;

   localparam logic [OP_W-1:0] OP_LDI         = 4'h0;
   localparam logic [OP_W-1:0] OP_ADD         = 4'h1;
   localparam logic [OP_W-1:0] OP_SUB         = 4'h2;
   localparam logic [OP_W-1:0] OP_AND         = 4'h3;
   localparam logic [OP_W-1:0] OP_OR          = 4'h4;
   localparam logic [OP_W-1:0] OP_XOR         = 4'h5;
   localparam logic [OP_W-1:0] OP_SHL         = 4'h6;
   localparam logic [OP_W-1:0] OP_SHR         = 4'h7;
   localparam logic [OP_W-1:0] OP_INC         = 4'h8;
   localparam logic [OP_W-1:0] OP_NOT         = 4'h9;
   localparam logic [OP_W-1:0] OP_DEC         = 4'hA;
   localparam logic [OP_W-1:0] OP_NAND        = 4'hB;
   localparam logic [OP_W-1:0] OP_XNOR        = 4'hC;
   localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'hD;

   localparam int FLG_Z = 0;
   localparam int FLG_S = 1;
   localparam int FLG_C = 2;
   localparam int FLG_V = 3;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   function automatic logic is_illegal(input logic [OP_W-1:0] op);
      return (op >= OP_ILLEGAL_MIN);
   endfunction

endpackage

// File: rtl/ula_regfile.sv
// Small register file: two combinational operand read ports, one debug read port,
// one synchronous write port, cleared by the asynchronous reset.
module ula_regfile
   import ula_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [REG_AW-1:0] i_raddr1,
   input  logic [REG_AW-1:0] i_raddr2,
   input  logic [REG_AW-1:0] i_dbg_addr,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2,
   output logic [DATA_W-1:0] o_dbg_data
);

   logic [DATA_W-1:0] r_regs [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1   = r_regs[i_raddr1];
   assign o_rdata2   = r_regs[i_raddr2];
   assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/ula_dispatch_unit.sv
// Execute-control stage for the 8-bit ULA: accepts one instruction at a time, feeds the ULA
// from the local register file and writes the result and flags back.
module ula_dispatch_unit
   import ula_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_instr_valid,
   output logic               o_instr_ready,
   input  logic [INSTR_W-1:0] i_instr,
   output logic [OP_W-1:0]    o_ula_operation,
   output logic [DATA_W-1:0]  o_operand1,
   output logic [DATA_W-1:0]  o_operand2,
   input  logic [DATA_W-1:0]  i_ula_result,
   input  logic [FLAG_W-1:0]  i_ula_flags,
   output logic [FLAG_W-1:0]  o_flag_reg,
   output logic               o_done,
   output logic               o_illegal_op,
   input  logic [REG_AW-1:0]  i_dbg_sel,
   output logic [DATA_W-1:0]  o_dbg_data
);

   state_t              r_state;
   logic                r_instr_ready;
   logic [OP_W-1:0]     r_ula_operation;
   logic [DATA_W-1:0]   r_operand1;
   logic [DATA_W-1:0]   r_operand2;
   logic [FLAG_W-1:0]   r_flag_reg;
   logic                r_done;
   logic                r_illegal_op;
   logic [REG_AW-1:0]   r_rd;

   logic [OP_W-1:0]     w_op;
   logic [REG_AW-1:0]   w_rd;
   logic [REG_AW-1:0]   w_rs1;
   logic [REG_AW-1:0]   w_rs2;
   logic [DATA_W-1:0]   w_imm;
   logic                w_accept;
   logic                w_ldi_wr;
   logic                w_wb_wr;
   logic                w_we;
   logic [REG_AW-1:0]   w_waddr;
   logic [DATA_W-1:0]   w_wdata;
   logic [DATA_W-1:0]   w_rdata1;
   logic [DATA_W-1:0]   w_rdata2;

   assign w_op  = i_instr[15:12];
   assign w_rd  = i_instr[11:10];
   assign w_rs1 = i_instr[9:8];
   assign w_rs2 = i_instr[7:6];
   assign w_imm = i_instr[7:0];

   assign w_accept = i_instr_valid && r_instr_ready;
   assign w_ldi_wr = w_accept && (w_op == OP_LDI);
   assign w_wb_wr  = (r_state == WB);

   // The two write sources never coincide: LDI only retires from IDLE, ALU results only from WB.
   assign w_we    = w_ldi_wr || w_wb_wr;
   assign w_waddr = w_wb_wr ? r_rd : w_rd;
   assign w_wdata = w_wb_wr ? i_ula_result : w_imm;

   ula_regfile u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (w_we),
      .i_waddr    (w_waddr),
      .i_wdata    (w_wdata),
      .i_raddr1   (w_rs1),
      .i_raddr2   (w_rs2),
      .i_dbg_addr (i_dbg_sel),
      .o_rdata1   (w_rdata1),
      .o_rdata2   (w_rdata2),
      .o_dbg_data (o_dbg_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_instr_ready   <= 1'b1;
         r_ula_operation <= '0;
         r_operand1      <= '0;
         r_operand2      <= '0;
         r_flag_reg      <= '0;
         r_done          <= 1'b0;
         r_illegal_op    <= 1'b0;
         r_rd            <= '0;
      end else begin
         r_done       <= 1'b0;
         r_illegal_op <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_rd <= w_rd;
                  if (w_op == OP_LDI) begin
                     r_done <= 1'b1;
                  end else if (is_illegal(w_op)) begin
                     r_illegal_op <= 1'b1;
                  end else begin
                     // Operands are captured here, so rd == rs1/rs2 sees the pre-write value.
                     r_operand1      <= w_rdata1;
                     r_operand2      <= w_rdata2;
                     r_ula_operation <= w_op;
                     r_instr_ready   <= 1'b0;
                     r_state         <= EXEC;
                  end
               end
            end
            EXEC: begin
               r_state <= WB;
            end
            WB: begin
               r_flag_reg      <= i_ula_flags;
               r_ula_operation <= '0;
               r_done          <= 1'b1;
               r_instr_ready   <= 1'b1;
               r_state         <= IDLE;
            end
            default: begin
               r_state       <= IDLE;
               r_instr_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_instr_ready   = r_instr_ready;
   assign o_ula_operation = r_ula_operation;
   assign o_operand1      = r_operand1;
   assign o_operand2      = r_operand2;
   assign o_flag_reg      = r_flag_reg;
   assign o_done          = r_done;
   assign o_illegal_op    = r_illegal_op;

endmodule
